// File: rtl/rf_write_arbiter_if.sv
// Writeback request / register-file write-port bundle for rf_write_arbiter.
// master = writeback side driving requests, slave = the arbiter.
interface rf_write_arbiter_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic                          a_valid;
    logic                          a_ready;
    logic [ADDRESS_WIDTH-1:0]      a_addr;
    logic [DATA_WIDTH-1:0]         a_data;
    logic                          b_valid;
    logic                          b_ready;
    logic [ADDRESS_WIDTH-1:0]      b_addr;
    logic [DATA_WIDTH-1:0]         b_data;
    logic                          we3;
    logic [ADDRESS_WIDTH-1:0]      ad3;
    logic [DATA_WIDTH-1:0]         wd3;
    logic [(2**ADDRESS_WIDTH)-1:0] pend_mask;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, we3, ad3, wd3, pend_mask
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, we3, ad3, wd3, pend_mask
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-port writeback arbiter for the register file's single write port, one-entry buffer per port.
// Optional stall counter (stall_cnt / stats_clr) enabled by defining RF_ARB_STATS_EN.
module rf_write_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rf_write_arbiter_if.slave     bus
`ifdef RF_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [15:0]           stall_cnt
`endif
);
    localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;

    function automatic logic [NUM_REGS-1:0] decode_addr(input logic [ADDRESS_WIDTH-1:0] addr);
        logic [NUM_REGS-1:0] onehot;
        onehot       = {NUM_REGS{1'b0}};
        onehot[addr] = 1'b1;
        return onehot;
    endfunction

    logic                     a_full_r;
    logic [ADDRESS_WIDTH-1:0] a_addr_r;
    logic [DATA_WIDTH-1:0]    a_data_r;
    logic                     b_full_r;
    logic [ADDRESS_WIDTH-1:0] b_addr_r;
    logic [DATA_WIDTH-1:0]    b_data_r;
    logic                     age_b_r;   // 1: B's entry was loaded first
    logic                     rr_b_r;    // 1: B wins the next contested, different-address cycle

    logic contested_s;
    logic same_addr_s;
    logic grant_a_s;
    logic grant_b_s;
    logic a_ready_s;
    logic b_ready_s;
    logic a_load_s;
    logic b_load_s;

    // Grant selection from current buffer state only
    always_comb begin
        grant_a_s   = 1'b0;
        grant_b_s   = 1'b0;
        contested_s = a_full_r && b_full_r;
        same_addr_s = (a_addr_r == b_addr_r);
        if (contested_s) begin
            if (same_addr_s) begin
                grant_b_s = age_b_r;
            end else begin
                grant_b_s = rr_b_r;
            end
            grant_a_s = !grant_b_s;
        end else begin
            grant_a_s = a_full_r;
            grant_b_s = b_full_r;
        end
    end

    // Handshake: a slot is free if empty or draining this cycle; register 0 is swallowed
    always_comb begin
        a_ready_s = !a_full_r || grant_a_s;
        b_ready_s = !b_full_r || grant_b_s;
        a_load_s  = bus.a_valid && a_ready_s && (bus.a_addr != {ADDRESS_WIDTH{1'b0}});
        b_load_s  = bus.b_valid && b_ready_s && (bus.b_addr != {ADDRESS_WIDTH{1'b0}});
    end

    // Register-file write port and pending-write mask
    always_comb begin
        bus.we3 = grant_a_s || grant_b_s;
        if (grant_a_s) begin
            bus.ad3 = a_addr_r;
            bus.wd3 = a_data_r;
        end else if (grant_b_s) begin
            bus.ad3 = b_addr_r;
            bus.wd3 = b_data_r;
        end else begin
            bus.ad3 = {ADDRESS_WIDTH{1'b0}};
            bus.wd3 = {DATA_WIDTH{1'b0}};
        end
        bus.pend_mask = (a_full_r ? decode_addr(a_addr_r) : {NUM_REGS{1'b0}})
                      | (b_full_r ? decode_addr(b_addr_r) : {NUM_REGS{1'b0}});
    end

    assign bus.a_ready = a_ready_s;
    assign bus.b_ready = b_ready_s;

    // Buffer, round-robin pointer and age flag update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full_r <= 1'b0;
            a_addr_r <= {ADDRESS_WIDTH{1'b0}};
            a_data_r <= {DATA_WIDTH{1'b0}};
            b_full_r <= 1'b0;
            b_addr_r <= {ADDRESS_WIDTH{1'b0}};
            b_data_r <= {DATA_WIDTH{1'b0}};
            age_b_r  <= 1'b0;
            rr_b_r   <= 1'b0;
        end else begin
            if (a_load_s) begin
                a_full_r <= 1'b1;
                a_addr_r <= bus.a_addr;
                a_data_r <= bus.a_data;
            end else if (grant_a_s) begin
                a_full_r <= 1'b0;
            end else begin
                a_full_r <= a_full_r;
            end

            if (b_load_s) begin
                b_full_r <= 1'b1;
                b_addr_r <= bus.b_addr;
                b_data_r <= bus.b_data;
            end else if (grant_b_s) begin
                b_full_r <= 1'b0;
            end else begin
                b_full_r <= b_full_r;
            end

            // Same-address ties are resolved by age, so they leave the pointer alone
            if (contested_s && !same_addr_s) begin
                rr_b_r <= grant_a_s;
            end else begin
                rr_b_r <= rr_b_r;
            end

            // A lone load is younger than whatever the other buffer still holds
            if (a_load_s && b_load_s) begin
                age_b_r <= 1'b0;
            end else if (a_load_s) begin
                age_b_r <= 1'b1;
            end else if (b_load_s) begin
                age_b_r <= 1'b0;
            end else begin
                age_b_r <= age_b_r;
            end
        end
    end

`ifdef RF_ARB_STATS_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles with both buffers occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'h0000;
        end else if (stats_clr) begin
            stall_cnt_r <= 16'h0000;
        end else if (contested_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: timestamp-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_rf_write_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
`ifdef RF_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] stall_cnt;
`endif

    rf_write_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rf_write_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef RF_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: each buffer holds an entry stamped with its load time
    bit            m_full  [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_data  [2];
    longint        m_stamp [2];
    bit            m_rr_b  = 1'b0;
    longint        m_time  = 0;
    int            m_stall = 0;
    logic [DW-1:0] m_rf [NR];
    logic [DW-1:0] d_rf [NR];
    logic [AW-1:0] wlog_a [$];
    logic [DW-1:0] wlog_d [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (m_full[0] && m_full[1]) begin
            if (m_addr[0] == m_addr[1]) return (m_stamp[1] < m_stamp[0]) ? 1 : 0;
            return m_rr_b ? 1 : 0;
        end
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    initial begin : model_proc
        int            g;
        bit            contest;
        bit            rdy [2];
        bit            vld [2];
        logic [AW-1:0] ad  [2];
        logic [DW-1:0] dt  [2];
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        forever begin
            @(posedge clk);
            vld[0] = bus.a_valid; ad[0] = bus.a_addr; dt[0] = bus.a_data;
            vld[1] = bus.b_valid; ad[1] = bus.b_addr; dt[1] = bus.b_data;
            if (!rst_n) begin
                m_full[0] = 1'b0;
                m_full[1] = 1'b0;
                m_rr_b    = 1'b0;
                m_stall   = 0;
            end else begin
                g       = model_grant();
                contest = m_full[0] && m_full[1];
`ifdef RF_ARB_STATS_EN
                if (stats_clr) m_stall = 0;
                else if (contest && m_stall < 65535) m_stall++;
`endif
                rdy[0] = !m_full[0] || (g == 0);
                rdy[1] = !m_full[1] || (g == 1);
                if (g >= 0) begin
                    m_rf[m_addr[g]] = m_data[g];
                    if (contest && (m_addr[0] != m_addr[1])) m_rr_b = (g == 0);
                    m_full[g] = 1'b0;
                end
                for (int p = 0; p < 2; p++) begin
                    if (vld[p] && rdy[p] && (ad[p] != 5'd0)) begin
                        m_full[p]  = 1'b1;
                        m_addr[p]  = ad[p];
                        m_data[p]  = dt[p];
                        m_stamp[p] = m_time;
                    end
                end
                m_time++;
            end
        end
    end

    initial begin : compare_proc
        int            g;
        logic [NR-1:0] exp_pend;
        logic [AW-1:0] exp_ad;
        logic [DW-1:0] exp_wd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_we3", bus.we3, 1'b0);
                check("rst_ad3", bus.ad3, 5'd0);
                check("rst_wd3", bus.wd3, 32'd0);
                check("rst_pend", bus.pend_mask, 32'd0);
                check("rst_a_ready", bus.a_ready, 1'b1);
                check("rst_b_ready", bus.b_ready, 1'b1);
`ifdef RF_ARB_STATS_EN
                check("rst_stall_cnt", stall_cnt, 16'd0);
`endif
            end else begin
                g        = model_grant();
                exp_pend = '0;
                exp_ad   = 5'd0;
                exp_wd   = 32'd0;
                for (int p = 0; p < 2; p++) if (m_full[p]) exp_pend[m_addr[p]] = 1'b1;
                if (g >= 0) begin
                    exp_ad = m_addr[g];
                    exp_wd = m_data[g];
                end
                check("we3", bus.we3, g >= 0);
                check("ad3", bus.ad3, exp_ad);
                check("wd3", bus.wd3, exp_wd);
                check("pend_mask", bus.pend_mask, exp_pend);
                check("a_ready", bus.a_ready, !m_full[0] || (g == 0));
                check("b_ready", bus.b_ready, !m_full[1] || (g == 1));
`ifdef RF_ARB_STATS_EN
                check("stall_cnt", stall_cnt, m_stall);
`endif
                if (bus.we3) begin
                    d_rf[bus.ad3] = bus.wd3;
                    wlog_a.push_back(bus.ad3);
                    wlog_d.push_back(bus.wd3);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input bit v, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        bus.a_valid = v; bus.a_addr = ad; bus.a_data = dt;
    endtask

    task automatic set_b(input bit v, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        bus.b_valid = v; bus.b_addr = ad; bus.b_data = dt;
    endtask

    task automatic clear_log();
        wlog_a.delete();
        wlog_d.delete();
    endtask

    initial begin : stim
        int            ia, ib, cyc;
        bit            ra, rb;
        bit            ra_log [$];
        bit            rb_log [$];
        logic [AW-1:0] sa [4];
        logic [AW-1:0] sb [4];
        logic [AW-1:0] exp_seq [6];
        bit            exp_ra [5];
        bit            exp_rb [5];

        for (int r = 0; r < NR; r++) begin
            m_rf[r] = 32'd0;
            d_rf[r] = 32'd0;
        end
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);

        // Reset, then idle
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("idle_we3", bus.we3, 1'b0);
        check("idle_pend", bus.pend_mask, 32'd0);
        tick();

        // Single uncontested write
        set_a(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("single_pend", bus.pend_mask, 32'h0000_0020);
        check("single_we3", bus.we3, 1'b1);
        check("single_ad3", bus.ad3, 5'd5);
        check("single_wd3", bus.wd3, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check("single_pend_after", bus.pend_mask, 32'd0);
        check("single_we3_after", bus.we3, 1'b0);
        tick();

        // Register 0 is discarded
        set_b(1'b1, 5'd0, 32'h1234);
        @(negedge clk);
        check("r0_b_ready", bus.b_ready, 1'b1);
        tick();
        set_b(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("r0_we3", bus.we3, 1'b0);
        check("r0_pend", bus.pend_mask, 32'd0);
        check("r0_b_ready_after", bus.b_ready, 1'b1);
        tick();
        @(negedge clk);
        check("r0_we3_late", bus.we3, 1'b0);
        tick();

        // Round-robin streaming with distinct addresses
        sa = '{5'd1, 5'd2, 5'd3, 5'd0};
        sb = '{5'd17, 5'd18, 5'd19, 5'd0};
        exp_seq = '{5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19};
        exp_ra  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_rb  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        clear_log();
        ia = 0; ib = 0; cyc = 0;
        while ((ia < 3 || ib < 3) && cyc < 40) begin
            set_a(ia < 3, sa[ia], 32'hA000_0000 + DW'(ia));
            set_b(ib < 3, sb[ib], 32'hB000_0000 + DW'(ib));
            @(negedge clk);
            ra = bus.a_ready;
            rb = bus.b_ready;
            ra_log.push_back(ra);
            rb_log.push_back(rb);
            @(posedge clk);
            if (bus.a_valid && ra) ia++;
            if (bus.b_valid && rb) ib++;
            #1;
            cyc++;
        end
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        check("rr_stream_cycles", cyc, 5);
        repeat (4) tick();
        check("rr_write_count", wlog_a.size(), 6);
        for (int i = 0; i < 6 && i < wlog_a.size(); i++) check("rr_ad3_seq", wlog_a[i], exp_seq[i]);
        for (int i = 0; i < 5 && i < ra_log.size(); i++) begin
            check("rr_a_ready_seq", ra_log[i], exp_ra[i]);
            check("rr_b_ready_seq", rb_log[i], exp_rb[i]);
        end

        // Reset with both buffers loaded: nothing gets written
        clear_log();
        set_a(1'b1, 5'd4, 32'h44);
        set_b(1'b1, 5'd6, 32'h66);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_pend", bus.pend_mask, 32'd0);
        check("midrst_we3", bus.we3, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("midrst_writes", wlog_a.size(), 0);

        // Same register from B then A: program order is kept
        clear_log();
        set_b(1'b1, 5'd7, 32'hB);
        tick();
        set_b(1'b0, 5'd0, 32'd0);
        set_a(1'b1, 5'd7, 32'hA);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        repeat (3) tick();
        check("order_write_count", wlog_d.size(), 2);
        if (wlog_d.size() >= 2) begin
            check("order_first", wlog_d[0], 32'hB);
            check("order_second", wlog_d[1], 32'hA);
        end
        check("order_final_r7", d_rf[7], 32'hA);

        // Same register loaded together while the pointer favours B: A (older) goes first
        clear_log();
        set_a(1'b1, 5'd1, 32'h11);
        set_b(1'b1, 5'd2, 32'h22);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        repeat (3) tick();
        set_a(1'b1, 5'd9, 32'hAA);
        set_b(1'b1, 5'd9, 32'hBB);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        repeat (3) tick();
        check("age_write_count", wlog_a.size(), 4);
        if (wlog_a.size() >= 4) begin
            check("age_ad3_0", wlog_a[0], 5'd1);
            check("age_ad3_1", wlog_a[1], 5'd2);
            check("age_wd3_2", wlog_d[2], 32'hAA);
            check("age_wd3_3", wlog_d[3], 32'hBB);
        end
        check("age_final_r9", d_rf[9], 32'hBB);

`ifdef RF_ARB_STATS_EN
        // Stall counter: 10 contested cycles, clear, then saturation
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        set_a(1'b1, 5'd10, 32'h1010);
        set_b(1'b1, 5'd11, 32'h1111);
        repeat (10) tick();
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        repeat (4) tick();
        check("stats_ten", stall_cnt, 16'd10);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        @(negedge clk);
        check("stats_clr", stall_cnt, 16'd0);
        tick();
        set_a(1'b1, 5'd12, 32'h1212);
        set_b(1'b1, 5'd13, 32'h1313);
        repeat (70000) tick();
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        repeat (4) tick();
        check("stats_saturate", stall_cnt, 16'hFFFF);
`endif

        // Register file contents seen by the DUT's write port against the model
        for (int r = 0; r < NR; r++) check("rf_contents", d_rf[r], m_rf[r]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
